// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage in front of the 64K x 16-bit Memory read port.
// Owns the program counter, drives the memory read address, and captures
// the combinational read data into a small prefetch FIFO. The FIFO head is
// offered to decode over a valid/ready handshake.
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   fetch_enable     in   1 = new fetches allowed; 0 = FIFO only drains
//   redirect_valid   in   flush FIFO and restart fetch at redirect_pc
//   redirect_pc      in   redirect target word address
//   mem_read_address out  memory read address (always the fetch PC)
//   mem_read_data    in   memory read data, combinational from the address
//   instr_valid      out  FIFO head valid
//   instr_ready      in   decode accepts the head this cycle
//   instr_data       out  head instruction word
//   instr_pc         out  head instruction address
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_enable,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic [15:0] mem_read_address,
   input  logic [15:0] mem_read_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [15:0] instr_data,
   output logic [15:0] instr_pc
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [15:0]      fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      fifo_q [DEPTH];
   logic [31:0]      fifo_d [DEPTH];
   logic             push;
   logic             pop;

   assign mem_read_address = fetch_pc_q;
   assign instr_valid      = (count_q != '0);
   assign instr_pc         = fifo_q[rd_ptr_q][31:16];
   assign instr_data       = fifo_q[rd_ptr_q][15:0];

   always_comb begin
      pop        = instr_valid && instr_ready;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push       = fetch_enable && !redirect_valid && ((count_q < DEPTH_C) || pop);
      fetch_pc_d = fetch_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      fifo_d     = fifo_q;

      if (push) begin
         fifo_d[wr_ptr_q] = {fetch_pc_q, mem_read_data};
      end

      if (redirect_valid) begin
         // A same-cycle pop was consumed by decode; everything else is dropped.
         fetch_pc_d = redirect_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + 16'd1;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Entry storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

endmodule
